// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM feeding a DEPTH-entry FIFO of {pc, instruction}
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   start, halt            : begin fetching at BOOT_ADDR / stop fetching and drain the buffer
//   redirect_valid/_addr   : taken branch target; a misaligned target is a sticky error
//   mem_addr, mem_data     : instruction memory port (mem_data is combinational for mem_addr)
//   inst_valid/_ready      : downstream handshake; inst_out/inst_pc show the oldest entry
//   busy, misaligned       : not IDLE / sticky misaligned-redirect flag
//   fetch_count/stall_count: performance counters, present only with FETCH_SEQ_PERF_EN
module fetch_sequencer #(
  parameter logic [63:0] BOOT_ADDR  = 64'd0,
  parameter logic [63:0] LIMIT_ADDR = 64'd600,
  parameter int          DEPTH      = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_addr,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        busy,
  output logic        misaligned,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ERROR} state_t;
  state_t state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, wr_q;
  logic [63:0] pc_buf [DEPTH];
  logic [31:0] ins_buf [DEPTH];
  logic pop, push, flush, mis_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign pop = inst_valid & inst_ready;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    push = 1'b0;
    flush = 1'b0;
    mis_d = misaligned;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        pc_d = BOOT_ADDR;
        flush = 1'b1;
      end
      FETCH: if (redirect_valid) begin
        flush = 1'b1;
        if (redirect_addr[1:0] == 2'b00) pc_d = redirect_addr;
        else begin
          mis_d = 1'b1;
          state_d = ERROR;
        end
      end else if (halt) state_d = DRAIN;
      else if (count_q < CW'(DEPTH) || pop) begin
        push = 1'b1;
        pc_d = pc_q + 64'd4;
        if (pc_d >= LIMIT_ADDR) state_d = DRAIN;
      end
      DRAIN: if (count_q == '0 || (count_q == CW'(1) && pop)) state_d = IDLE;
      default: ;
    endcase
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q <= BOOT_ADDR;
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      misaligned <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      count_q <= count_d;
      misaligned <= mis_d;
      rd_q <= flush ? '0 : pop ? nxt(rd_q) : rd_q;
      wr_q <= flush ? '0 : push ? nxt(wr_q) : wr_q;
    end
  always_ff @(posedge clock)
    if (push) begin
      pc_buf[wr_q] <= pc_q;
      ins_buf[wr_q] <= mem_data;
    end
  assign inst_valid = count_q != '0;
  assign inst_out = inst_valid ? ins_buf[rd_q] : '0;
  assign inst_pc = inst_valid ? pc_buf[rd_q] : '0;
  assign busy = state_q != IDLE;
  assign mem_addr = pc_q;
`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push && ~&fetch_count) fetch_count <= fetch_count + 32'd1;
      if (state_q == FETCH && inst_valid && !inst_ready && ~&stall_count) stall_count <= stall_count + 32'd1;
    end
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, halt = 1'b0, rv = 1'b0, ready = 1'b0, l_start = 1'b0;
  logic [63:0] raddr = '0, mem_addr, inst_pc, l_mem, l_pc;
  logic [31:0] mem_data, inst_out, fc, sc, l_data, l_out, l_fc, l_sc;
  logic inst_valid, busy, mis, l_valid, l_busy, l_mis;
  int tests = 0, fails = 0;
  assign mem_data = mem_addr[33:2];
  assign l_data = l_mem[33:2];
  always #5 clock = ~clock;
  fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .halt(halt),
    .redirect_valid(rv), .redirect_addr(raddr), .mem_addr(mem_addr), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_ready(ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .busy(busy), .misaligned(mis), .fetch_count(fc), .stall_count(sc));
  fetch_sequencer #(.LIMIT_ADDR(64'd16)) u_lim (
    .clock(clock), .reset_n(reset_n), .start(l_start), .halt(1'b0),
    .redirect_valid(1'b0), .redirect_addr(64'd0), .mem_addr(l_mem), .mem_data(l_data),
    .inst_valid(l_valid), .inst_ready(1'b1), .inst_out(l_out), .inst_pc(l_pc),
    .busy(l_busy), .misaligned(l_mis), .fetch_count(l_fc), .stall_count(l_sc));
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rst();
    reset_n = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    rv = 1'b0;
    ready = 1'b0;
    l_start = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask
  initial begin
    rst();
    chk("rst_valid", inst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_mis", mis, 0);
    chk("rst_fc", fc, 0);
    chk("rst_sc", sc, 0);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", inst_valid, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("seq_pc", inst_pc, 64'(4 * k));
      chk("seq_out", inst_out, 64'(k));
      chk("seq_fc", fc, PERF ? 64'(k + 1) : 64'd0);
    end
    rst();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("stall_pc", inst_pc, 0);
    chk("stall_addr", mem_addr, 8);
    chk("stall_sc", sc, PERF ? 64'd5 : 64'd0);
    chk("stall_fc", fc, PERF ? 64'd2 : 64'd0);
    ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("resume_pc", inst_pc, 64'(4 * k));
      chk("resume_out", inst_out, 64'(k));
    end
    chk("resume_sc", sc, PERF ? 64'd5 : 64'd0);
    rst();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    chk("pre_redir_pc", inst_pc, 8);
    rv = 1'b1;
    raddr = 64'h40;
    tick();
    rv = 1'b0;
    ready = 1'b1;
    chk("redir_valid", inst_valid, 0);
    chk("redir_addr", mem_addr, 64'h40);
    tick();
    chk("redir_pc", inst_pc, 64'h40);
    chk("redir_out", inst_out, 64'h10);
    rv = 1'b1;
    raddr = 64'h42;
    tick();
    rv = 1'b0;
    chk("err_mis", mis, 1);
    chk("err_valid", inst_valid, 0);
    chk("err_busy", busy, 1);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("err_stay_busy", busy, 1);
    chk("err_stay_valid", inst_valid, 0);
    chk("err_stay_mis", mis, 1);
    rst();
    chk("err_clr_mis", mis, 0);
    chk("err_clr_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_busy", busy, 1);
    chk("halt_addr", mem_addr, 8);
    chk("halt_pc", inst_pc, 0);
    ready = 1'b1;
    tick();
    chk("drain_pc", inst_pc, 4);
    chk("drain_out", inst_out, 1);
    chk("drain_busy", busy, 1);
    tick();
    chk("drained_busy", busy, 0);
    chk("drained_valid", inst_valid, 0);
    chk("drained_addr", mem_addr, 8);
    rst();
    l_start = 1'b1;
    tick();
    l_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lim_pc", l_pc, 64'(4 * k));
      chk("lim_out", l_out, 64'(k));
    end
    chk("lim_busy", l_busy, 1);
    tick();
    chk("lim_idle", l_busy, 0);
    chk("lim_valid", l_valid, 0);
    chk("lim_addr", l_mem, 16);
    rst();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("arst_pre_valid", inst_valid, 1);
    chk("arst_pre_pc", inst_pc, 4);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", inst_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_pc", inst_pc, 0);
    chk("arst_out", inst_out, 0);
    chk("arst_fc", fc, 0);
    tick();
    chk("arst_edge_valid", inst_valid, 0);
    chk("arst_edge_busy", busy, 0);
    reset_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 64'd0, byte address of the first fetch after start.
REQ-002 SHALL have parameter LIMIT_ADDR, default 64'd600, first byte address not fetched (150 words x 4).
REQ-003 SHALL have parameter DEPTH, default 2, instruction buffer entries (legal range 2..8).
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  pulse; begins fetching at BOOT_ADDR when IDLE.
REQ-007 halt  in  1  stop issuing new fetches; drain the buffer.
REQ-008 redirect_valid  in  1  branch/jump taken this cycle.
REQ-009 redirect_addr  in  64  byte target of the redirect.
REQ-010 mem_addr  out  64  byte address to the instruction memory; equals PC.
REQ-011 mem_data  in  32  instruction word, combinationally valid for mem_addr in the same cycle.
REQ-012 inst_valid / inst_ready  out / in  1 / 1  downstream handshake; transfer when both are high at a rising edge.
REQ-013 inst_out / inst_pc  out  32 / 64  head-of-buffer instruction and its byte address.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 misaligned  out  1  sticky error flag.
REQ-016 fetch_count / stall_count  out  32 / 32  performance counters (see Configuration).

Function
REQ-017 SHALL implement the states IDLE, FETCH, DRAIN and ERROR.
REQ-018 IDLE: start=1 -> PC<=BOOT_ADDR, buffer cleared, next state FETCH; all other inputs are ignored.
REQ-019 FETCH: push {PC, mem_data} and PC<=PC+4 in every cycle where the buffer count is below DEPTH, or equals DEPTH while a pop occurs in the same cycle.
REQ-020 Buffer SHALL be FIFO; inst_valid = (count != 0); inst_out/inst_pc SHALL show the oldest entry; a pop and a push in the same cycle SHALL leave count unchanged.
REQ-021 redirect_valid=1 in FETCH with redirect_addr[1:0]==0 -> buffer flushed (count<=0), no push that cycle, PC<=redirect_addr; a pop in the same cycle SHALL still be considered completed.
REQ-022 redirect_valid=1 in FETCH with redirect_addr[1:0]!=0 -> flush, misaligned<=1, next state ERROR.
REQ-023 redirect_valid SHALL be ignored in IDLE, DRAIN and ERROR.
REQ-024 FETCH: a push that makes PC+4 >= LIMIT_ADDR, or halt=1, -> next state DRAIN; halt SHALL suppress the push in that same cycle.
REQ-025 A redirect SHALL take priority over halt and the limit condition in the same cycle.
REQ-026 DRAIN: no pushes; when count reaches 0 (including via a pop this cycle) -> IDLE.
REQ-027 ERROR: no pushes, buffer empty, inst_valid=0; SHALL remain in ERROR until reset.
REQ-028 mem_addr SHALL always equal PC, including in states that do not fetch.
REQ-029 PC arithmetic SHALL be 64-bit unsigned, wrapping modulo 2^64.

Reset
REQ-030 On reset_n=0, asynchronously: state IDLE, PC=BOOT_ADDR, count=0, inst_valid=0, inst_out=0, inst_pc=0, busy=0, misaligned=0, fetch_count=0, stall_count=0.
REQ-031 A reset asserted mid-FETCH or mid-DRAIN SHALL discard buffered instructions; no handshake SHALL complete in that cycle.

Configuration
REQ-032 With FETCH_SEQ_PERF_EN defined: fetch_count SHALL increment on each push, and stall_count SHALL increment on each FETCH cycle where inst_valid=1 and inst_ready=0; both SHALL saturate at 32'hFFFFFFFF.
REQ-033 Without FETCH_SEQ_PERF_EN: fetch_count and stall_count SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-034 Memory word[i]=i, inst_ready=1, start pulse -> in-order pairs (inst_pc, inst_out) = (0,0), (4,1), (8,2), ... one per cycle.
REQ-035 inst_ready=0 for 5 cycles after start -> count saturates at 2, PC stops at 8, no pair is lost or duplicated after inst_ready=1; stall_count=5 with the macro defined.
REQ-036 Redirect to 0x40 while the buffer holds pc 8 and 12 -> next delivered inst_pc=0x40; pc 8 and 12 are never delivered.
REQ-037 Redirect to 0x42 -> misaligned=1, state ERROR, inst_valid=0; start is ignored; reset_n pulse clears both.
REQ-038 LIMIT_ADDR=16 -> exactly pc 0, 4, 8, 12 delivered, then busy falls to 0 once drained; halt mid-run -> buffered entries delivered, then IDLE.
REQ-039 reset_n asserted asynchronously between clock edges mid-FETCH -> all outputs reach reset values immediately; no transfer at the next edge.
